// File: rtl/acumulador_seq.sv
// acumulador_seq: sequencing controller for a 16-bit accumulator datapath.
// Clears the running sum, streams `count` operands over valid/ready, and
// issues `load` and, one cycle later, the matching `transf` pulse for each
// operand, so a back-to-back stream is summed at one operand per clock.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for start; count latched on start
// S_CLR   | clear_n low for this one cycle; empty jobs skip straight to done
// S_ACC   | in_ready high; each accept loads an operand and counts down
// S_DRAIN | transf for the final operand; no new operands accepted
// S_DONE  | done pulse; the sum is final at the accumulator output
module acumulador_seq #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] count,
  input  logic          abort,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          load,
  output logic          transf,
  output logic          clear_n,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_ACC,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] remaining;
  logic [CW-1:0] remaining_nxt;
  logic          clear_n_nxt;
  logic          accept;
  logic          abort_act;

  // abort is ignored in IDLE, where there is nothing to cancel
  assign abort_act = abort & (state != S_IDLE);
  assign in_ready  = (state == S_ACC);
  assign accept    = in_valid & in_ready;
  // load stays purely combinational, even in an aborted cycle
  assign load      = accept;
  assign busy      = (state != S_IDLE);

  // State, remaining counter and the registered transf/clear_n outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      remaining <= '0;
      transf    <= 1'b0;
      clear_n   <= 1'b1;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
      // the operand captured this cycle is added next cycle unless cancelled
      transf    <= accept & ~abort_act;
      clear_n   <= clear_n_nxt;
    end
  end

  // Next-state, counter update and done decode; abort overrides everything
  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    clear_n_nxt   = 1'b1;
    done          = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          remaining_nxt = count;
          clear_n_nxt   = 1'b0;
          state_nxt     = S_CLR;
        end
      end
      S_CLR: begin
        if (remaining == '0) state_nxt = S_DONE;
        else                 state_nxt = S_ACC;
      end
      S_ACC: begin
        if (accept) begin
          // remaining is at least 1 here, so this never wraps
          remaining_nxt = remaining - CW'(1);
          if (remaining == CW'(1)) state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    if (abort_act) begin
      state_nxt     = S_IDLE;
      remaining_nxt = '0;
      clear_n_nxt   = 1'b1;
      done          = 1'b0;
    end
  end

endmodule

// File: doc/acumulador_seq.md
# acumulador_seq

Sequencing controller for the 16-bit accumulator datapath (operand register plus running-sum register with `load`, `transf` and active-low `clear` controls). On a `start` command it clears the sum, accepts exactly `count` operands over a valid/ready stream, and issues each operand's `load` and matching `transf` pulses. The controller pipelines these so one operand is summed per clock, then signals `done`. It sits between the operand source and the accumulator; operand data goes straight to the accumulator's `in` bus, and only control passes through this block.

## Interface

- `CW`, default 8, width of the operand-count field and the internal remaining counter.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  command pulse; sampled only in IDLE.
- `count`  in  CW  number of operands to accumulate; latched on accepted `start`.
- `abort`  in  1  cancels a running job; sampled in every non-IDLE state.
- `in_valid`  in  1  source has an operand on the accumulator `in` bus.
- `in_ready`  out  1  controller accepts an operand this cycle.
- `load`  out  1  to accumulator `load`; high in the cycle an operand is accepted.
- `transf`  out  1  to accumulator `transf`; high in the cycle after each accepted operand.
- `clear_n`  out  1  to accumulator `clear`; low for exactly one cycle per job.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the final sum is valid at the accumulator output.

## Operation

- Reset values: state IDLE, `remaining` 0, `transf` 0, `clear_n` 1, `in_ready` 0, `load` 0, `busy` 0, `done` 0.
- `accept` = `in_valid & in_ready`. `load` = `accept`, which is combinational. `transf` is a register loaded with `accept` and cleared on `rst` or `abort`. `clear_n` is a registered output.
- FSM states: IDLE, CLR, ACC, DRAIN, DONE.
  - IDLE: if `start`=1, latch `count` into `remaining`, set `clear_n` to 0 for the next cycle, and go to CLR.
  - CLR: `clear_n`=0. If `remaining`=0, go to DONE. Otherwise go to ACC.
  - ACC: `in_ready`=1. On `accept`, decrement `remaining`. On `accept` with `remaining`=1, go to DRAIN. With no `accept`, stay in ACC indefinitely.
  - DRAIN: `in_ready`=0. `transf`=1 for the last operand. Go to DONE.
  - DONE: `done`=1 for one cycle. Go to IDLE.
- Pipelining: `load` for operand k+1 and `transf` for operand k may be high in the same cycle. The accumulator adds the previously registered operand while capturing the new one, which gives the correct sum. A back-to-back stream sums 1 operand per clock.
- Gaps in `in_valid` during ACC produce gaps in `transf`. There is no loss or duplication.
- `start` outside IDLE is ignored. `count` is sampled only when `start` is accepted.
- `abort` in CLR, ACC, DRAIN or DONE: next state IDLE, `remaining` set to 0, `transf` set to 0, `clear_n` set to 1. No `done` pulse is issued. The accumulator contents are then undefined.
- `abort` takes priority over `accept` in the same cycle. `load` still follows `accept` combinationally, but no `transf` follows it.
- `rst` mid-job behaves like `abort`, except that every register returns to its reset value.
- `remaining` never wraps: a decrement only occurs in ACC, where `remaining` ≥ 1.

## Timing

- Job with N ≥ 1 operands and `in_valid` held high:
  - `start` at cycle 0.
  - `clear_n` low in cycle 1 (CLR).
  - `load` in cycles 2 to N+1.
  - `transf` in cycles 3 to N+2.
  - `done` in cycle N+3.
  - Total latency from `start` to `done` is N+3 cycles.
- N=0: `start` at 0, CLR at 1, `done` at 2. There are no `load` or `transf` pulses and the sum is 0.
- At the cycle of `done`, the accumulator output already holds the final sum, committed at the edge closing DRAIN.
- `busy` goes high in the cycle after `start` is accepted and low in the cycle after DONE. A new `start` is accepted in the first IDLE cycle.

## Test plan

- Reset: assert `rst` for 2 cycles with `start`=1. Required: all outputs at their reset values, and the FSM stays in IDLE until `rst`=0.
- Streaming: `count`=4, operands 3, 5, 7, 9 with `in_valid` always high. Required: `load` in cycles 2–5, `transf` in cycles 3–6, `done` in cycle 7, and an accumulator sum of 24.
- Stalls: `count`=3, operands 0xFFFF, 1, 2, with `in_valid` low for 2 cycles between each operand. Required: exactly 3 `load` and 3 `transf` pulses, and a sum of 0x0002 (16-bit wrap).
- Zero count: `count`=0. Required: a single-cycle `clear_n` low pulse, `done` at cycle 2, no `in_ready`, and a sum of 0.
- Abort: `count`=5, assert `abort` with the third `accept`. Required: IDLE next cycle, `transf` low from that cycle onward, no `done` pulse, and a following `start` with `count`=1 and operand 7 yields a sum of 7.
- `start` while busy: pulse `start` with `count`=9 during ACC of a `count`=2 job. Required: the second `start` is ignored, and exactly 2 operands are accepted.
